// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the writeback path
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int RF_ADDR_W = 5;
  localparam logic [RF_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result FIFO exposing per-entry valid and rd for hazard compare
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic [CW-1:0]                       count,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]     ent_rd
);
  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage needs no reset; the valid bits decide what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // Pointers wrap naturally at the power-of-two depth; valid bits track occupancy per entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= wr_ptr + 1'b1;
        ent_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + 1'b1;
        ent_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flatten the stored destination registers for the pending-write compare.
  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges ALU and load writebacks onto the register file write port
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [RF_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [RF_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  input  logic [RF_ADDR_W-1:0] q1,
  input  logic [RF_ADDR_W-1:0] q2,
  output logic                 q1_pend,
  output logic                 q2_pend,
  output logic                 we3,
  output logic [RF_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]      wd3,
  output logic [CW-1:0]        fifo_count
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                              alu_ready_q;
  logic [SW-1:0]                     starve;
  wb_req_t                           head;
  logic [DEPTH-1:0]                  ent_valid;
  logic [DEPTH-1:0][RF_ADDR_W-1:0]   ent_rd;
  logic                              alu_win;
  logic                              ld_push;
  logic                              fifo_pop;
  logic                              fifo_empty;

  assign alu_ready  = alu_ready_q;
  assign fifo_empty = (fifo_count == '0);
  assign ld_ready   = (fifo_count != CW'(DEPTH));
  // x0 requests still handshake but never claim the port or a FIFO slot.
  assign alu_win    = alu_valid && alu_ready_q && (alu_rd != REG_X0);
  assign ld_push    = ld_valid && ld_ready && (ld_rd != REG_X0);
  // A forced-load cycle blocks the ALU, so !alu_win also covers it.
  assign fifo_pop   = !fifo_empty && !alu_win;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ld_push),
    .push_req  ('{rd: ld_rd, data: ld_data}),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Output register: FIFO head beats ALU only when the ALU did not win; idle holds a3/wd3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (fifo_pop) begin
      we3 <= 1'b1;
      a3  <= head.rd;
      wd3 <= head.data;
    end else if (alu_win) begin
      we3 <= 1'b1;
      a3  <= alu_rd;
      wd3 <= alu_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  // Starvation counter: after STARVE_LIMIT ALU wins over a waiting load, block the ALU one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve      <= '0;
      alu_ready_q <= 1'b1;
    end else begin
      alu_ready_q <= 1'b1;
      if (fifo_pop || fifo_empty) begin
        starve <= '0;
      end else if (alu_win) begin
        if (starve == SW'(STARVE_LIMIT - 1)) begin
          starve      <= '0;
          alu_ready_q <= 1'b0;
        end else begin
          starve <= starve + 1'b1;
        end
      end
    end
  end

  // Pending writes: the output register plus every occupied FIFO entry.
  always_comb begin
    q1_pend = 1'b0;
    q2_pend = 1'b0;
    if (we3 && a3 == q1) q1_pend = 1'b1;
    if (we3 && a3 == q2) q2_pend = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_rd[i] == q1) q1_pend = 1'b1;
      if (ent_valid[i] && ent_rd[i] == q2) q2_pend = 1'b1;
    end
    if (q1 == REG_X0) q1_pend = 1'b0;
    if (q2 == REG_X0) q2_pend = 1'b0;
  end
endmodule
